// File: rtl/matrix_scan_reader.sv
// matrix_scan_reader: scans a GS x GS key/sensor matrix one row at a time,
// debounces each bit across successive frames and publishes a flat image in
// the same r*GS+c bit layout the LED matrix display consumes.
module matrix_scan_reader #(
    parameter int unsigned GS         = 8,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned DEB_FRAMES = 3
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               e_scan_i,
    input  logic [GS-1:0]      col_val_i,
    output logic [GS-1:0]      row_val_o,
    output logic [GS*GS-1:0]   matrix_o,
    output logic [GS*GS-1:0]   raw_o,
    output logic               d_scan_o,
    output logic               changed_o
);

    localparam int unsigned RW = (GS > 1) ? $clog2(GS) : 1;
    localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDone
    } state_t;

    state_t                state_q;
    logic [RW-1:0]         row_q;
    logic [CW-1:0]         cnt_q;
    // Frame under construction; each row slice is overwritten before publish.
    logic [GS*GS-1:0]      raw_acc_q;
    // Raw frame history, index 0 = newest.
    logic [GS*GS-1:0]      hist_q [DEB_FRAMES];

    logic [GS*GS-1:0]      frame_d;
    logic [GS*GS-1:0]      hist_d [DEB_FRAMES];
    logic [GS*GS-1:0]      all_one;
    logic [GS*GS-1:0]      any_one;
    logic [GS*GS-1:0]      matrix_d;
    logic                  settle_last;
    logic                  row_last;

    assign settle_last = (cnt_q == CW'(SETTLE_CYC - 1));
    assign row_last    = (row_q == RW'(GS - 1));

    // Frame with the current row's columns merged in, plus the debounce result
    // that would be published if this edge completes the frame.
    always_comb begin
        frame_d = raw_acc_q;
        frame_d[int'(row_q) * GS +: GS] = col_val_i;

        hist_d[0] = frame_d;
        for (int unsigned i = 1; i < DEB_FRAMES; i++) begin
            hist_d[i] = hist_q[i - 1];
        end

        all_one = '1;
        any_one = '0;
        for (int unsigned i = 0; i < DEB_FRAMES; i++) begin
            all_one = all_one & hist_d[i];
            any_one = any_one | hist_d[i];
        end

        // Unanimous 1 sets, unanimous 0 clears, anything mixed holds.
        matrix_d = all_one | (matrix_o & any_one);
    end

    // Scan FSM with registered row drive, capture, debounce and status pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_q     <= '0;
            cnt_q     <= '0;
            raw_acc_q <= '0;
            for (int unsigned i = 0; i < DEB_FRAMES; i++) begin
                hist_q[i] <= '0;
            end
            row_val_o <= '0;
            matrix_o  <= '0;
            raw_o     <= '0;
            d_scan_o  <= 1'b0;
            changed_o <= 1'b0;
        end else begin
            d_scan_o  <= 1'b0;
            changed_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    row_val_o <= '0;
                    if (e_scan_i) begin
                        state_q   <= StDrive;
                        row_q     <= '0;
                        cnt_q     <= '0;
                        row_val_o <= GS'(1);
                    end
                end
                StDrive: begin
                    if (settle_last) begin
                        // Only the final settle cycle is sampled.
                        cnt_q     <= '0;
                        raw_acc_q <= frame_d;
                        if (row_last) begin
                            state_q   <= StDone;
                            row_val_o <= '0;
                            hist_q    <= hist_d;
                            raw_o     <= frame_d;
                            matrix_o  <= matrix_d;
                            d_scan_o  <= 1'b1;
                            changed_o <= (matrix_d != matrix_o);
                        end else begin
                            row_q     <= row_q + RW'(1);
                            row_val_o <= row_val_o << 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    if (e_scan_i) begin
                        state_q   <= StDrive;
                        row_q     <= '0;
                        cnt_q     <= '0;
                        row_val_o <= GS'(1);
                    end else begin
                        state_q   <= StIdle;
                        row_val_o <= '0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    row_val_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_reader.sv
// Bench for matrix_scan_reader: a key-matrix model answers the row drive,
// expected frames are queued when stimulus is set and checked on d_scan_o.
module tb_matrix_scan_reader;

    localparam logic [63:0] DIAG = 64'h8040_2010_0804_0201;
    localparam logic [63:0] B27  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] R2   = 64'h0000_0000_00FF_0000;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        e_scan_i;
    logic [7:0]  col_val_i;
    logic [7:0]  row_val_o;
    logic [63:0] matrix_o;
    logic [63:0] raw_o;
    logic        d_scan_o;
    logic        changed_o;

    logic [63:0] keys = '0;
    logic        ovr_en = 1'b0;
    logic [7:0]  ovr_val = '0;
    logic [7:0]  key_cols;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [63:0] raw;
        logic [63:0] mat;
        logic        ch;
    } exp_t;

    typedef struct {
        logic [63:0] keys;
        logic [63:0] raw;
        logic [63:0] mat;
        logic        ch;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[13];

    always #5 clk_i = ~clk_i;

    matrix_scan_reader dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .e_scan_i  (e_scan_i),
        .col_val_i (col_val_i),
        .row_val_o (row_val_o),
        .matrix_o  (matrix_o),
        .raw_o     (raw_o),
        .d_scan_o  (d_scan_o),
        .changed_o (changed_o)
    );

    // Key matrix: a pressed key shorts its row drive onto its column line.
    always_comb begin
        key_cols = '0;
        for (int r = 0; r < 8; r++) begin
            if (row_val_o[r]) key_cols = key_cols | keys[r*8 +: 8];
        end
    end
    assign col_val_i = ovr_en ? ovr_val : key_cols;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push(logic [63:0] r, logic [63:0] m, logic c);
        exp_t e;
        e.raw = r;
        e.mat = m;
        e.ch  = c;
        sb_q.push_back(e);
    endfunction

    // Scoreboard consumer: one expected frame per d_scan_o pulse.
    always @(negedge clk_i) begin
        if (d_scan_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_frame", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("frame_raw", raw_o, e.raw);
                chk("frame_matrix", matrix_o, e.mat);
                chk("frame_changed", 64'(changed_o), 64'(e.ch));
            end
        end
    end

    task automatic wait_done(input string name);
        bit ok = 0;
        @(negedge clk_i);
        for (int i = 0; i < 300; i++) begin
            if (d_scan_o === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk_i);
        end
        chk({name, "_done_timeout"}, 64'(ok), 64'(1));
    endtask

    task automatic wait_row(input logic [7:0] v, input string name);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (row_val_o === v) begin
                ok = 1;
                break;
            end
        end
        chk({name, "_row_timeout"}, 64'(ok), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;

        vecs[0]  = '{DIAG, DIAG, 64'h0, 1'b0};
        vecs[1]  = '{DIAG, DIAG, 64'h0, 1'b0};
        vecs[2]  = '{DIAG, DIAG, DIAG,  1'b1};
        vecs[3]  = '{DIAG, DIAG, DIAG,  1'b0};
        vecs[4]  = '{B27,  B27,  DIAG,  1'b0};
        vecs[5]  = '{B27,  B27,  DIAG,  1'b0};
        vecs[6]  = '{B27,  B27,  B27,   1'b1};
        vecs[7]  = '{64'h0, 64'h0, B27, 1'b0};
        vecs[8]  = '{B27,  B27,  B27,   1'b0};
        vecs[9]  = '{B27,  B27,  B27,   1'b0};
        vecs[10] = '{64'h0, 64'h0, B27, 1'b0};
        vecs[11] = '{64'h0, 64'h0, B27, 1'b0};
        vecs[12] = '{64'h0, 64'h0, 64'h0, 1'b1};

        // Reset held with scan enabled.
        rst_n    = 1'b0;
        e_scan_i = 1'b1;
        keys     = vecs[0].keys;
        repeat (3) @(negedge clk_i);
        chk("rst_row_val", 64'(row_val_o), 64'(0));
        chk("rst_matrix", matrix_o, 64'h0);
        chk("rst_raw", raw_o, 64'h0);
        chk("rst_d_scan", 64'(d_scan_o), 64'(0));
        chk("rst_changed", 64'(changed_o), 64'(0));

        // Frame 1 with row-stepping timing checks.
        push(vecs[0].raw, vecs[0].mat, vecs[0].ch);
        rst_n = 1'b1;
        @(negedge clk_i);
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 16; k++) begin
                if (k == 0 || k == 15) chk("row_step", 64'(row_val_o), 64'(8'(1) << r));
                if (k == 15) chk("no_early_d_scan", 64'(d_scan_o), 64'(0));
                @(negedge clk_i);
            end
        end
        chk("frame_end_d_scan", 64'(d_scan_o), 64'(1));
        chk("frame_end_row_val", 64'(row_val_o), 64'(0));

        // Remaining table frames under continuous scan.
        for (int i = 1; i < 13; i++) begin
            keys = vecs[i].keys;
            push(vecs[i].raw, vecs[i].mat, vecs[i].ch);
            wait_done("table");
        end

        // Settle window: only the last settle cycle of row 2 is captured.
        push(64'h0, 64'h0, 1'b0);
        wait_row(8'h04, "settle_a");
        ovr_en  = 1'b1;
        ovr_val = 8'hFF;
        repeat (15) @(negedge clk_i);
        ovr_val = 8'h00;
        @(negedge clk_i);
        ovr_en = 1'b0;
        wait_done("settle_a");

        push(R2, 64'h0, 1'b0);
        wait_row(8'h04, "settle_b");
        ovr_en  = 1'b1;
        ovr_val = 8'h00;
        repeat (15) @(negedge clk_i);
        ovr_val = 8'hFF;
        @(negedge clk_i);
        ovr_en = 1'b0;
        wait_done("settle_b");

        // Scan disable mid-frame: frame completes, then the FSM idles.
        push(64'h0, 64'h0, 1'b0);
        wait_row(8'h10, "drop");
        e_scan_i = 1'b0;
        wait_done("drop");
        bad = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (row_val_o !== 8'h00 || d_scan_o !== 1'b0) bad = 1;
        end
        chk("idle_after_drop", 64'(bad), 64'(0));

        // Build a debounced image, then reset during row 5.
        keys = DIAG;
        push(DIAG, 64'h0, 1'b0);
        push(DIAG, 64'h0, 1'b0);
        push(DIAG, DIAG, 1'b1);
        e_scan_i = 1'b1;
        wait_done("pre_rst");
        wait_done("pre_rst");
        wait_done("pre_rst");
        chk("pre_rst_matrix", matrix_o, DIAG);
        wait_row(8'h20, "mid_rst");
        rst_n = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_row_val", 64'(row_val_o), 64'(0));
        chk("mid_rst_matrix", matrix_o, 64'h0);
        chk("mid_rst_raw", raw_o, 64'h0);
        chk("mid_rst_d_scan", 64'(d_scan_o), 64'(0));
        chk("mid_rst_changed", 64'(changed_o), 64'(0));

        // History was cleared, so three frames are needed again.
        push(DIAG, 64'h0, 1'b0);
        push(DIAG, 64'h0, 1'b0);
        push(DIAG, DIAG, 1'b1);
        rst_n = 1'b1;
        wait_done("restart");
        wait_done("restart");
        wait_done("restart");
        @(negedge clk_i);

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
